// File: rtl/io_timer_responder.sv
// rtl/io_timer_responder.sv - IO-space bus responder with wait states and a prescaled down-counter timer
module io_timer_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h0010,
  parameter int          WAIT_STATES = 2,
  parameter int          PRESCALE    = 4
) (
  input  logic        clk,
  input  logic        arst,
  input  logic [21:0] address_bus,
  input  logic        mem_io,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        wait_n,
  output logic        irq_req
);
  localparam logic [3:0] WS_INIT    = 4'(WAIT_STATES);
  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_HOLD} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic        sel, start, strobes_idle;
  logic [2:0]  lat_off;
  logic        lat_write;
  logic [7:0]  lat_data;
  logic        reg_we, reg_re;
  logic [7:0]  reload_l, reload_h, rd_data;
  logic        ctrl_en, ctrl_auto, ctrl_irq_en, expired;
  logic [15:0] count;
  logic [7:0]  presc, shadow;
  logic        tick, load, expire;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^address_bus[21:16];
  assign sel            = !mem_io && (address_bus[15:3] == BASE_ADDR[15:3]);
  assign start          = sel && (rd_n ^ wr_n);
  assign strobes_idle   = rd_n && wr_n;
  assign reg_we         = (state == ST_ACCESS) && lat_write;
  assign reg_re         = (state == ST_ACCESS) && !lat_write;

  // Reset lands in HOLD so a strobe left low across reset must be released first.
  always_ff @(posedge clk) begin
    if (arst) begin
      state    <= ST_HOLD;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    wait_n       = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (WS_INIT == 4'd0) begin
            state_nxt = ST_ACCESS;
          end else begin
            state_nxt    = ST_WAIT;
            wait_cnt_nxt = WS_INIT;
          end
        end
      end
      ST_WAIT: begin
        wait_n = 1'b0;
        if (wait_cnt == 4'd1) state_nxt = ST_ACCESS;
        else                  wait_cnt_nxt = wait_cnt - 4'd1;
      end
      ST_ACCESS: state_nxt = ST_HOLD;
      ST_HOLD:   if (strobes_idle) state_nxt = ST_IDLE;
      default:   state_nxt = ST_HOLD;
    endcase
  end

  always_comb begin
    rd_data = 8'h00;
    case (lat_off)
      3'd0:    rd_data = reload_l;
      3'd1:    rd_data = reload_h;
      3'd2:    rd_data = count[7:0];
      3'd3:    rd_data = shadow;
      3'd4:    rd_data = {5'b0, ctrl_irq_en, ctrl_auto, ctrl_en};
      3'd5:    rd_data = {7'b0, expired};
      default: rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      lat_off   <= 3'd0;
      lat_write <= 1'b0;
      lat_data  <= 8'h00;
      data_out  <= 8'h00;
      data_oe   <= 1'b0;
      shadow    <= 8'h00;
    end else begin
      if (state == ST_IDLE && start) begin
        lat_off   <= address_bus[2:0];
        lat_write <= !wr_n;
        lat_data  <= data_in;
      end
      if (reg_re) begin
        data_out <= rd_data;
        data_oe  <= 1'b1;
        if (lat_off == 3'd2) shadow <= count[15:8];
      end else if (state == ST_HOLD && strobes_idle) begin
        data_oe <= 1'b0;
      end
    end
  end

  // Load (EN 0->1) needs EN low and a tick needs EN high, so they never collide.
  assign tick   = ctrl_en && (presc == PRESC_LAST);
  assign expire = tick && (count == 16'd0);
  assign load   = reg_we && (lat_off == 3'd4) && lat_data[0] && !ctrl_en;

  always_ff @(posedge clk) begin
    if (arst) begin
      presc       <= 8'h00;
      count       <= 16'h0000;
      reload_l    <= 8'h00;
      reload_h    <= 8'h00;
      ctrl_en     <= 1'b0;
      ctrl_auto   <= 1'b0;
      ctrl_irq_en <= 1'b0;
      expired     <= 1'b0;
      irq_req     <= 1'b0;
    end else begin
      if (!ctrl_en || load || tick) presc <= 8'h00;
      else                          presc <= presc + 8'd1;
      if (load) begin
        count <= {reload_h, reload_l};
      end else if (tick) begin
        if (count != 16'd0) count <= count - 16'd1;
        else if (ctrl_auto) count <= {reload_h, reload_l};
      end
      if (expire && !ctrl_auto) ctrl_en <= 1'b0;
      // Expiry beats a simultaneous write-1-to-clear.
      if (expire)                                         expired <= 1'b1;
      else if (reg_we && lat_off == 3'd5 && lat_data[0])  expired <= 1'b0;
      irq_req <= expired & ctrl_irq_en;
      if (reg_we) begin
        case (lat_off)
          3'd0:    reload_l <= lat_data;
          3'd1:    reload_h <= lat_data;
          3'd4:    {ctrl_irq_en, ctrl_auto, ctrl_en} <= lat_data[2:0];
          default: ;
        endcase
      end
    end
  end
endmodule
